// File: rtl/text_term_ctrl_if.sv
// rtl/text_term_ctrl_if.sv - byte input stream and character-RAM write port of the terminal controller
interface text_term_ctrl_if #(
  parameter int ADDR_W = 13
) ();
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/text_term_ctrl.sv
// rtl/text_term_ctrl.sv - ANSI-subset terminal controller: cursor, char-RAM writes, line lengths, ESC[ parser
// Optional screen clear on ESC[2J is built only with TEXT_TERM_CLEAR_EN defined.
module text_term_ctrl #(
  parameter  int COLS   = 80,
  parameter  int ROWS   = 60,
  parameter  int ADDR_W = 13,
  localparam int XW     = $clog2(COLS),
  localparam int YW     = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              resetn,
  text_term_ctrl_if.slave   bus,
  output logic [XW-1:0]     cur_x,
  output logic [YW-1:0]     cur_y,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [XW:0]       cur_len
);

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_ESC = 8'h1B;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_LB  = 8'h5B;

  typedef enum logic [1:0] {
    IDLE,
    ESC,
    CSI
`ifdef TEXT_TERM_CLEAR_EN
    , CLEAR
`endif
  } state_t;

  state_t state, state_n;

  logic [XW:0]       line_len [ROWS];
  logic [XW-1:0]     x_n;
  logic [YW-1:0]     y_n;
  logic              we_n;
  logic [ADDR_W-1:0] wa_n;
  logic [7:0]        wd_n;
  logic              len_we;
  logic [XW:0]       len_n;
  logic              clr_all;

  logic              accept;
  logic [7:0]        b;
  logic              is_print, is_param, is_final;
  logic              x_last, y_last;
  logic [XW-1:0]     x_inc, x_dec;
  logic [YW-1:0]     y_inc, y_dec;
  logic [XW:0]       x_plus1;

`ifdef TEXT_TERM_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS*ROWS-1);
  logic              p2, p2_n;
  logic              seen, seen_n;
  logic [ADDR_W-1:0] clr_addr, clr_n;
  assign bus.in_ready = resetn && (state != CLEAR);
`else
  assign bus.in_ready = resetn;
`endif

  assign accept   = bus.in_valid && bus.in_ready;
  assign b        = bus.in_data;
  assign is_print = (b >= 8'h20) && (b <= 8'h7E);
  assign is_param = (b[7:4] == 4'h3);
  assign is_final = (b >= 8'h40) && (b <= 8'h7E);

  assign cur_addr = ADDR_W'(cur_y) * ADDR_W'(COLS) + ADDR_W'(cur_x);
  assign cur_len  = line_len[cur_y];

  assign x_last  = (cur_x == XW'(COLS-1));
  assign y_last  = (cur_y == YW'(ROWS-1));
  assign x_inc   = x_last ? '0 : cur_x + XW'(1);
  assign x_dec   = (cur_x == '0) ? XW'(COLS-1) : cur_x - XW'(1);
  assign y_inc   = y_last ? '0 : cur_y + YW'(1);
  assign y_dec   = (cur_y == '0) ? YW'(ROWS-1) : cur_y - YW'(1);
  assign x_plus1 = {1'b0, cur_x} + (XW+1)'(1);

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    x_n     = cur_x;
    y_n     = cur_y;
    we_n    = 1'b0;
    wa_n    = bus.wr_addr;
    wd_n    = bus.wr_data;
    len_we  = 1'b0;
    len_n   = cur_len;
    clr_all = 1'b0;
`ifdef TEXT_TERM_CLEAR_EN
    p2_n    = p2;
    seen_n  = seen;
    clr_n   = clr_addr;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_print) begin
            we_n   = 1'b1;
            wa_n   = cur_addr;
            wd_n   = b;
            len_we = 1'b1;
            len_n  = (cur_len > x_plus1) ? cur_len : x_plus1;
            x_n    = x_inc;
            if (x_last) y_n = y_inc;
          end else if (b == CH_CR) begin
            x_n = '0;
          end else if (b == CH_LF) begin
            y_n = y_inc;
          end else if (b == CH_BS) begin
            // The blank lands on the cell the cursor moves back onto.
            if (cur_x != '0) begin
              x_n  = cur_x - XW'(1);
              we_n = 1'b1;
              wa_n = cur_addr - ADDR_W'(1);
              wd_n = CH_SP;
            end
          end else if (b == CH_ESC) begin
            state_n = ESC;
`ifdef TEXT_TERM_CLEAR_EN
            p2_n    = 1'b0;
            seen_n  = 1'b0;
`endif
          end
        end
      end
      ESC: begin
        if (accept) state_n = (b == CH_LB) ? CSI : IDLE;
      end
      CSI: begin
        if (accept) begin
          if (is_param) begin
`ifdef TEXT_TERM_CLEAR_EN
            p2_n   = !seen && (b == 8'h32);
            seen_n = 1'b1;
`endif
          end else if (is_final) begin
            state_n = IDLE;
            case (b)
              8'h41: y_n = y_dec;
              8'h42: y_n = y_inc;
              8'h43: x_n = x_inc;
              8'h44: x_n = x_dec;
`ifdef TEXT_TERM_CLEAR_EN
              8'h4A: begin
                if (p2) begin
                  state_n = CLEAR;
                  clr_n   = '0;
                end
              end
`endif
              default: ;
            endcase
          end else begin
            state_n = IDLE;
          end
        end
      end
`ifdef TEXT_TERM_CLEAR_EN
      CLEAR: begin
        we_n = 1'b1;
        wa_n = clr_addr;
        wd_n = CH_SP;
        if (clr_addr == LAST_ADDR) begin
          state_n = IDLE;
          x_n     = '0;
          y_n     = '0;
          clr_all = 1'b1;
          clr_n   = '0;
        end else begin
          clr_n = clr_addr + ADDR_W'(1);
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cur_x       <= '0;
      cur_y       <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      for (int r = 0; r < ROWS; r++) line_len[r] <= '0;
    end else begin
      cur_x       <= x_n;
      cur_y       <= y_n;
      bus.wr_en   <= we_n;
      bus.wr_addr <= wa_n;
      bus.wr_data <= wd_n;
      if (clr_all) begin
        for (int r = 0; r < ROWS; r++) line_len[r] <= '0;
      end else if (len_we) begin
        line_len[cur_y] <= len_n;
      end
    end
  end

`ifdef TEXT_TERM_CLEAR_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      p2       <= 1'b0;
      seen     <= 1'b0;
      clr_addr <= '0;
    end else begin
      p2       <= p2_n;
      seen     <= seen_n;
      clr_addr <= clr_n;
    end
  end
`endif

endmodule
